// File: rtl/obi_ram_bridge_pkg.sv
// Shared types and constants for the OBI-to-RAM bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package obi_ram_bridge_pkg;

    // Grant-stall FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } stall_state_e;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Response register contents, captured at every handshake.
    typedef struct packed {
        logic valid;
        logic is_read;
        logic err;
    } resp_t;

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with feedback into bit 0 when en_i is high.
// Latency: q_o updates one cycle after en_i.
// Backpressure: none; holds its value while en_i is low.
// Ports: clk_i/rst_ni clock and async active-low reset, en_i step enable,
//        seed_i reset value (zero replaced by default seed), q_o current state.
module lfsr16
    import obi_ram_bridge_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [15:0] seed_i,
    output logic [15:0] q_o
);

    logic fb;

    assign fb = ^(q_o & LFSR_TAPS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= lfsr_seed_fix(seed_i);
        end else if (en_i) begin
            q_o <= {q_o[14:0], fb};
        end
    end

endmodule

// File: rtl/obi_ram_bridge.sv
// OBI front-end for a single-port 4-lane RAM with optional random grant stalls.
// Latency: grant 0 cycles (0-3 with stalls), response exactly 1 cycle after handshake.
// Backpressure: gnt_o withheld for 0-3 request cycles by an LFSR-driven stall FSM.
// Ports: OBI slave (req/gnt/addr/we/be/wdata, rvalid/rdata/err) and RAM master
//        (ram_en/addr/we/be/wdata strobes, ram_rdata registered one cycle after address).
module obi_ram_bridge
    import obi_ram_bridge_pkg::*;
#(
    parameter int unsigned  ADDR_WIDTH = 12,
    parameter bit           STALL_EN   = 1'b0,
    parameter logic [15:0]  LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    stall_state_e state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [1:0]   stall_n;
    logic         lfsr_en;
    logic [15:0]  lfsr_q;
    logic         unused_lfsr_hi;
    logic         in_range;
    logic         hs;
    resp_t        resp_q, resp_d;

    lfsr16 u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (lfsr_en),
        .seed_i (LFSR_SEED),
        .q_o    (lfsr_q)
    );

    // Only the two low LFSR bits pick the stall length.
    assign unused_lfsr_hi = ^lfsr_q[15:2];
    assign stall_n        = STALL_EN ? lfsr_q[1:0] : 2'd0;

    assign in_range = (addr_i[31:ADDR_WIDTH] == '0);
    assign hs       = req_i && gnt_o;

    // RAM strobes follow the OBI inputs; only the enable is qualified.
    assign ram_en_o    = hs && in_range;
    assign ram_addr_o  = addr_i[ADDR_WIDTH-1:0];
    assign ram_we_o    = we_i;
    assign ram_be_o    = be_i;
    assign ram_wdata_o = wdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A stall of n cycles grants on the (n+1)th request cycle; the LFSR
    // advances once per transaction, on its first request cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_o   = 1'b0;
        lfsr_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    lfsr_en = 1'b1;
                    if (stall_n == 2'd0) begin
                        gnt_o = 1'b1;
                    end else begin
                        cnt_d   = stall_n;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (req_i) begin
                    if (cnt_q == 2'd1) begin
                        gnt_o   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end else begin
                    // Request withdrawn before grant: abandon it silently.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Rewritten every cycle so a response lasts exactly one cycle.
    always_comb begin
        resp_d.valid   = hs;
        resp_d.is_read = hs && !we_i && in_range;
        resp_d.err     = hs && !in_range;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign rvalid_o = resp_q.valid;
    assign err_o    = resp_q.err;
    assign rdata_o  = resp_q.is_read ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_obi_ram_bridge.sv
// Self-checking bench: dut0 (no stalls) and dut1 (stalls, seed 0xACE1), each with its own RAM.
// Latency: responses checked one cycle after each modelled handshake.
// Backpressure: dut1 grant timing predicted per transaction from an LFSR reference.
module tb_obi_ram_bridge;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut0 signals
    logic        req, we, gnt, rvalid, err, ram_en, ram_we;
    logic [31:0] addr, wdata, rdata, ram_wdata;
    logic [3:0]  be, ram_be;
    logic [11:0] ram_addr;
    bit   [31:0] ram_rdata;
    // dut1 signals
    logic        s_req, s_we, s_gnt, s_rvalid, s_err, s_ram_en, s_ram_we;
    logic [31:0] s_addr, s_wdata, s_rdata, s_ram_wdata;
    logic [3:0]  s_be, s_ram_be;
    logic [11:0] s_ram_addr;
    bit   [31:0] s_ram_rdata;

    obi_ram_bridge #(.ADDR_WIDTH(12), .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata));

    obi_ram_bridge #(.ADDR_WIDTH(12), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(s_req), .gnt_o(s_gnt), .addr_i(s_addr), .we_i(s_we),
        .be_i(s_be), .wdata_i(s_wdata), .rvalid_o(s_rvalid), .rdata_o(s_rdata), .err_o(s_err),
        .ram_en_o(s_ram_en), .ram_addr_o(s_ram_addr), .ram_we_o(s_ram_we), .ram_be_o(s_ram_be),
        .ram_wdata_o(s_ram_wdata), .ram_rdata_i(s_ram_rdata));

    // Testbench RAMs: 1024 words, byte-lane writes, registered read.
    bit [31:0] mem0 [1024];
    bit [31:0] mem1 [1024];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem0[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem0[ram_addr[11:2]];
        end
        if (s_ram_en) begin
            if (s_ram_we)
                for (int b = 0; b < 4; b++)
                    if (s_ram_be[b]) mem1[s_ram_addr[11:2]][8*b +: 8] <= s_ram_wdata[8*b +: 8];
            s_ram_rdata <= mem1[s_ram_addr[11:2]];
        end
    end

    // Reference state
    bit [31:0]   m0 [1024];
    bit [31:0]   m1 [1024];
    logic [15:0] lf;
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        x_gnt;
        logic        x_en;
        logic        x_rv;
        logic        x_err;
        logic [31:0] x_rdata;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [15:0] lstep(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] bm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // dut1 fresh after reset: seed low bits 01 -> one stall cycle.
    task automatic stall_seq(input string tag);
        lf = lstep(16'hACE1);
        @(negedge clk);
        s_req = 1'b1; s_we = 1'b0; s_addr = 32'h10; s_be = 4'hF; s_wdata = 32'h0;
        #1 chk({tag, " stall c0 gnt"}, s_gnt, 1'b0);
        @(negedge clk);
        #1 chk({tag, " stall c1 gnt"}, s_gnt, 1'b1);
        chk({tag, " stall c1 rvalid"}, s_rvalid, 1'b0);
        @(negedge clk);
        s_req = 1'b0;
        #1 chk({tag, " stall c2 rvalid"}, s_rvalid, 1'b1);
        chk({tag, " stall c2 rdata"}, s_rdata, m1[4]);
    endtask

    logic        e_rv, e_err, inr, hs, have;
    logic [31:0] e_rd;
    logic [1:0]  n;
    int          waited;

    initial begin
        for (int i = 0; i < 1024; i++) begin m0[i] = 32'h0; m1[i] = 32'h0; end
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
        s_req = 1'b0; s_we = 1'b0; s_addr = 32'h0; s_be = 4'h0; s_wdata = 32'h0;

        tbl[0]  = '{1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'hA000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h0000_0004, 4'hF, 32'hA000_0004, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h0000_0008, 4'hF, 32'hA000_0008, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 32'h0000_0020, 4'h3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_BEEF};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'hA000_0000};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'hA000_0004};
        tbl[11] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0008};
        tbl[12] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 32'hFFFF_F000, 4'hF, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0};

        // Reset values
        @(negedge clk);
        #1 chk("rst rvalid", rvalid, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst gnt", gnt, 1'b0);
        chk("rst ram_en", ram_en, 1'b0);
        chk("rst s_gnt", s_gnt, 1'b0);
        chk("rst s_rvalid", s_rvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        stall_seq("init");

        // Directed table on dut0
        foreach (tbl[i]) begin
            @(negedge clk);
            req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr;
            be = tbl[i].be; wdata = tbl[i].wdata;
            #1;
            chk($sformatf("tbl%0d gnt", i), gnt, tbl[i].x_gnt);
            chk($sformatf("tbl%0d ram_en", i), ram_en, tbl[i].x_en);
            chk($sformatf("tbl%0d rvalid", i), rvalid, tbl[i].x_rv);
            chk($sformatf("tbl%0d err", i), err, tbl[i].x_err);
            chk($sformatf("tbl%0d rdata", i), rdata, tbl[i].x_rdata);
            if (tbl[i].req && tbl[i].we && tbl[i].addr[31:12] == 20'h0)
                m0[tbl[i].addr[11:2]] = merge(m0[tbl[i].addr[11:2]], tbl[i].wdata, tbl[i].be);
        end

        // Random traffic on dut0, checked every cycle
        e_rv = 1'b0; e_err = 1'b0; e_rd = 32'h0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req = ($urandom_range(0, 9) < 7);
            we = $urandom_range(0, 1) == 1;
            inr = ($urandom_range(0, 9) != 0);
            addr = inr ? {20'h0, 12'($urandom)} : ($urandom | 32'h0001_0000);
            be = 4'($urandom); wdata = $urandom;
            #1;
            chk($sformatf("rnd%0d gnt", c), gnt, req);
            chk($sformatf("rnd%0d ram_en", c), ram_en, req && inr);
            chk($sformatf("rnd%0d ram_addr", c), ram_addr, addr[11:0]);
            chk($sformatf("rnd%0d ram_we", c), ram_we, we);
            chk($sformatf("rnd%0d ram_be", c), ram_be, be);
            chk($sformatf("rnd%0d ram_wdata", c), ram_wdata, wdata);
            chk($sformatf("rnd%0d rvalid", c), rvalid, e_rv);
            chk($sformatf("rnd%0d err", c), err, e_err);
            chk($sformatf("rnd%0d rdata", c), rdata, e_rd);
            e_rv  = req;
            e_err = req && !inr;
            e_rd  = (req && inr && !we) ? m0[addr[11:2]] : 32'h0;
            if (req && inr && we) m0[addr[11:2]] = merge(m0[addr[11:2]], wdata, be);
        end
        @(negedge clk);
        req = 1'b0;

        // Random transactions on dut1: each one waits lfsr[1:0] request cycles
        have = 1'b0; waited = 0; n = 2'd0;
        e_rv = 1'b0; e_err = 1'b0; e_rd = 32'h0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!have && $urandom_range(0, 3) != 0) begin
                have = 1'b1; waited = 0;
                n = lf[1:0]; lf = lstep(lf);
                s_we = $urandom_range(0, 1) == 1;
                inr = ($urandom_range(0, 7) != 0);
                s_addr = inr ? {20'h0, 12'($urandom)} : ($urandom | 32'h0010_0000);
                s_be = 4'($urandom); s_wdata = $urandom;
            end
            s_req = have;
            #1;
            hs = have && (waited == int'(n));
            chk($sformatf("stl%0d gnt", c), s_gnt, hs);
            chk($sformatf("stl%0d rvalid", c), s_rvalid, e_rv);
            chk($sformatf("stl%0d err", c), s_err, e_err);
            chk($sformatf("stl%0d rdata", c), s_rdata, e_rd);
            inr = (s_addr[31:12] == 20'h0);
            e_rv  = hs;
            e_err = hs && !inr;
            e_rd  = (hs && inr && !s_we) ? m1[s_addr[11:2]] : 32'h0;
            if (hs && inr && s_we) m1[s_addr[11:2]] = merge(m1[s_addr[11:2]], s_wdata, s_be);
            if (hs) have = 1'b0;
            else if (have) waited++;
        end
        @(negedge clk);
        s_req = 1'b0;
        #1 chk("stl tail rvalid", s_rvalid, e_rv);

        // Reset between a handshake and its response edge drops the response
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        s_req = 1'b1; s_we = 1'b0; s_addr = 32'h0;
        #1 chk("rstmid gnt", gnt, 1'b1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        req = 1'b0; s_req = 1'b0;
        #1 chk("rstmid rvalid during", rvalid, 1'b0);
        chk("rstmid s_rvalid during", s_rvalid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("rstmid rvalid after", rvalid, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        #1 chk("post-rst gnt", gnt, 1'b1);
        @(negedge clk);
        req = 1'b0;
        #1 chk("post-rst rvalid", rvalid, 1'b1);
        chk("post-rst err", err, 1'b0);
        chk("post-rst rdata", rdata, m0[4]);
        stall_seq("post-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
